// File: rtl/mem_port_arbiter_if.sv
// Requester-side request/response bundle for the scratch-memory arbiter.
// master = requester, slave = arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  valid;
   logic                  ready;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output valid, we, addr, wdata,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  valid, we, addr, wdata,
      output ready, rvalid, rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin two-requester arbiter for a single-port synchronous memory,
// with read-response routing and a whole-memory clear sweep.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mem_port_arbiter_if.slave     a,
   mem_port_arbiter_if.slave     b,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic {ARB, CLEAR} state_t;

   // One extra bit so a sweep of 2**ADDR_WIDTH words terminates correctly.
   localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);

   state_t              state_reg, state_next;
   logic [ADDR_WIDTH:0] cnt_reg, cnt_next;
   logic                last_b_reg, last_b_next;
   logic                a_rvalid_reg, b_rvalid_reg;
   logic                clr_done_reg, clr_done_next;
   logic                grant_a, grant_b;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ARB;
         cnt_reg      <= '0;
         last_b_reg   <= 1'b1;
         a_rvalid_reg <= 1'b0;
         b_rvalid_reg <= 1'b0;
         clr_done_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         last_b_reg   <= last_b_next;
         a_rvalid_reg <= grant_a && !a.we;
         b_rvalid_reg <= grant_b && !b.we;
         clr_done_reg <= clr_done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      last_b_next   = last_b_reg;
      clr_done_next = 1'b0;
      grant_a       = 1'b0;
      grant_b       = 1'b0;
      case (state_reg)
         ARB: begin
            if (clr_start) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end else begin
               // On a tie the requester that did not win last time goes first.
               grant_a = a.valid && (!b.valid || last_b_reg);
               grant_b = b.valid && (!a.valid || !last_b_reg);
               if (grant_a)
                  last_b_next = 1'b0;
               else if (grant_b)
                  last_b_next = 1'b1;
            end
         end
         CLEAR: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_CNT) begin
               state_next    = ARB;
               clr_done_next = 1'b1;
            end
         end
         default: state_next = ARB;
      endcase
   end

   always_comb begin
      a.ready   = rst_n && grant_a;
      b.ready   = rst_n && grant_b;
      a.rvalid  = rst_n && a_rvalid_reg;
      b.rvalid  = rst_n && b_rvalid_reg;
      a.rdata   = mem_rdata;
      b.rdata   = mem_rdata;
      clr_busy  = rst_n && (state_reg == CLEAR);
      clr_done  = rst_n && clr_done_reg;
      mem_we    = 1'b0;
      mem_addr  = a.addr;
      mem_wdata = a.wdata;
      if (state_reg == CLEAR) begin
         mem_we    = rst_n;
         mem_addr  = cnt_reg[ADDR_WIDTH-1:0];
         mem_wdata = '0;
      end else if (grant_b) begin
         mem_we    = rst_n && b.we;
         mem_addr  = b.addr;
         mem_wdata = b.wdata;
      end else begin
         mem_we    = rst_n && grant_a && a.we;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised + directed bench for mem_port_arbiter: a cycle-level reference
// model predicts grants and read responses; a monitor scores the responses.
module tb_mem_port_arbiter;
   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr_start = 1'b0;
   logic          clr_busy, clr_done, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_if ();
   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_if ();

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a_if),
      .b         (b_if),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Scratch memory: registered read, read-before-write.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit            owner_b;
      logic [DW-1:0] data;
      int            due;
   } resp_t;
   resp_t exp_q[$];

   // Reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   int            m_clr_left = 0;
   bit            m_done_pend = 0;
   bit            m_last_b = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input bit rstn, input bit clr,
                       input bit av, input bit awe, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit bv, input bit bwe, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
      bit            e_ra, e_rb, e_we, e_busy, e_done, pick_b;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      @(posedge clk);
      #1;
      rst_n = rstn; clr_start = clr;
      a_if.valid = av; a_if.we = awe; a_if.addr = aa; a_if.wdata = ad;
      b_if.valid = bv; b_if.we = bwe; b_if.addr = ba; b_if.wdata = bd;
      e_ra = 0; e_rb = 0; e_we = 0; e_busy = 0; e_done = 0; pick_b = 0;
      e_addr = '0; e_wdata = '0;
      if (!rstn) begin
         m_clr_left = 0; m_done_pend = 0; m_last_b = 1;
         while (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
      end else if (m_clr_left > 0) begin
         e_busy = 1; e_we = 1;
         e_addr = AW'(DEPTH - m_clr_left); e_wdata = '0;
         ref_mem[DEPTH - m_clr_left] = '0;
         m_clr_left--;
         if (m_clr_left == 0) m_done_pend = 1;
      end else begin
         e_done = m_done_pend; m_done_pend = 0;
         if (clr) begin
            m_clr_left = DEPTH;
         end else if (av || bv) begin
            pick_b = bv && (!av || !m_last_b);
            m_last_b = pick_b;
            e_ra = !pick_b; e_rb = pick_b;
            if (pick_b ? bwe : awe) begin
               e_we = 1;
               e_addr = pick_b ? ba : aa;
               e_wdata = pick_b ? bd : ad;
               ref_mem[e_addr] = e_wdata;
            end else begin
               exp_q.push_back('{pick_b, ref_mem[pick_b ? ba : aa], cyc + 1});
            end
         end
      end
      @(negedge clk);
      check("a_ready", 32'(a_if.ready), 32'(e_ra));
      check("b_ready", 32'(b_if.ready), 32'(e_rb));
      check("clr_busy", 32'(clr_busy), 32'(e_busy));
      check("clr_done", 32'(clr_done), 32'(e_done));
      check("mem_we", 32'(mem_we), 32'(e_we));
      if (e_we) begin
         check("mem_addr", 32'(mem_addr), 32'(e_addr));
         check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic wr_a(input logic [AW-1:0] ad, input logic [DW-1:0] d);
      step(1, 0, 1, 1, ad, d, 0, 0, '0, '0);
   endtask

   task automatic rd_a(input logic [AW-1:0] ad);
      step(1, 0, 1, 0, ad, '0, 0, 0, '0, '0);
   endtask

   // Response monitor: scores every rvalid against the predicted queue.
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            r = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL resp_missing cycle %0d: got no rvalid, expected %s data %0h at cycle %0d",
                     cyc, r.owner_b ? "B" : "A", r.data, r.due);
         end
         if (a_if.rvalid || b_if.rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected cycle %0d: got a_rvalid=%0b b_rvalid=%0b, expected none",
                        cyc, a_if.rvalid, b_if.rvalid);
            end else begin
               r = exp_q.pop_front();
               if (r.due != cyc || a_if.rvalid == b_if.rvalid || b_if.rvalid != r.owner_b ||
                   (r.owner_b ? b_if.rdata : a_if.rdata) !== r.data) begin
                  errors++;
                  $display("FAIL resp cycle %0d: got a_rvalid=%0b b_rvalid=%0b a_rdata=%0h b_rdata=%0h, expected %s data %0h at cycle %0d",
                           cyc, a_if.rvalid, b_if.rvalid, a_if.rdata, b_if.rdata,
                           r.owner_b ? "B" : "A", r.data, r.due);
               end else begin
                  $display("resp %s data %0h cycle %0d", r.owner_b ? "B" : "A", r.data, cyc);
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = DW'($urandom);
         ref_mem[i] = mem[i];
      end
      a_if.valid = 0; a_if.we = 0; a_if.addr = '0; a_if.wdata = '0;
      b_if.valid = 0; b_if.we = 0; b_if.addr = '0; b_if.wdata = '0;
      step(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
      step(0, 0, 1, 0, '0, '0, 1, 0, '0, '0);

      // Single requester write then read
      wr_a(4'd3, 8'h5A);
      rd_a(4'd3);
      idle(2);

      // Contention from reset: A first, then alternate
      step(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
      for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 4'd1, '0, 1, 0, 4'd2, '0);

      // A write and B read of the same address in the same cycle
      step(1, 0, 1, 1, 4'd7, 8'h11, 1, 0, 4'd7, '0);
      step(1, 0, 0, 0, '0, '0, 1, 0, 4'd7, '0);
      idle(2);

      // Full clear with A waiting
      for (int i = 0; i < DEPTH; i++) wr_a(AW'(i), 8'hFF);
      step(1, 1, 1, 0, 4'd0, '0, 0, 0, '0, '0);
      for (int i = 0; i < DEPTH + 1; i++) rd_a(4'd0);
      for (int i = 0; i < DEPTH; i++) rd_a(AW'(i));
      idle(2);

      // Reset in the fifth clear cycle
      for (int i = 0; i < DEPTH; i++) wr_a(AW'(i), 8'hFF);
      step(1, 1, 0, 0, '0, '0, 0, 0, '0, '0);
      idle(4);
      step(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
      idle(2);
      for (int i = 0; i < DEPTH; i++) rd_a(AW'(i));
      idle(2);

      // Read blocked by clr_start; read in flight into a clear
      step(1, 1, 1, 0, 4'd2, '0, 0, 0, '0, '0);
      idle(DEPTH + 1);
      rd_a(4'd5);
      step(1, 1, 0, 0, '0, '0, 1, 0, 4'd6, '0);
      idle(DEPTH + 2);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 199) != 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom));
      end
      idle(DEPTH + 4);

      check("resp_queue_empty", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < DEPTH; i++) check($sformatf("mem_content[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
